// File: rtl/sense_pulse_gen_pkg.sv
// ---------------------------------------------------------------------------
// sense_pulse_gen_pkg : channel encoding and engine state shared with the heart model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sense_pulse_gen_pkg;

  localparam logic CHAN_A = 1'b0;
  localparam logic CHAN_V = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } eng_state_e;

endpackage

`default_nettype wire

// File: rtl/sense_pulse_gen_if.sv
// ---------------------------------------------------------------------------
// sense_pulse_gen_if : valid/ready sense request channel from the heart model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sense_pulse_gen_if;
  logic req_valid;
  logic req_chan;
  logic req_ready;

  modport master (output req_valid, output req_chan, input req_ready);
  modport slave  (input req_valid, input req_chan, output req_ready);
endinterface

`default_nettype wire

// File: rtl/sense_pulse_gen_chan_engine.sv
// ---------------------------------------------------------------------------
// sense_chan_engine : one channel IDLE->PULSE->GAP engine with event counter
// Optional SENSE_BLANK_EN adds a pace synchronizer and blanking window.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sense_chan_engine
  import sense_pulse_gen_pkg::*;
#(
  parameter int PULSE_CYCLES = 100,
  parameter int GAP_CYCLES   = 50,
  parameter int BLANK_CYCLES = 2000,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  output logic        ready_o,
`ifdef SENSE_BLANK_EN
  input  logic        pace_i,
  output logic        drop_o,
`endif
  output logic        pulse_o,
  output logic        busy_o,
  output logic [15:0] cnt_o
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  eng_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             pulse_q;
  logic             take;
  logic             blanked;

`ifdef SENSE_BLANK_EN
  logic [2:0]       pace_sync_q;
  logic [CNT_W-1:0] blank_q;
  logic             pace_edge;

  // [0..1] synchronize, [2] holds the previous sample for the rising-edge detect
  assign pace_edge = pace_sync_q[1] & ~pace_sync_q[2];
  assign blanked   = (blank_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pace_sync_q <= '0;
      blank_q     <= '0;
    end else begin
      pace_sync_q <= {pace_sync_q[1:0], pace_i};
      if (pace_edge) begin
        blank_q <= CNT_W'(BLANK_CYCLES);
      end else if (blank_q != '0) begin
        blank_q <= blank_q - 1'b1;
      end
    end
  end

  assign drop_o = take & blanked;
`else
  assign blanked = 1'b0;
`endif

  assign ready_o = (state_q == IDLE) && !rst;
  assign take    = req_i & ready_o;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (take && !blanked) begin
          state_d = PULSE;
          timer_d = PULSE_LOAD;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      PULSE: begin
        if (timer_q == '0) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            timer_d = GAP_LOAD;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      pulse_q <= (state_d == PULSE);
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = (state_q != IDLE);
  assign cnt_o   = cnt_q;

endmodule

`default_nettype wire

// File: rtl/sense_pulse_gen.sv
// ---------------------------------------------------------------------------
// sense_pulse_gen : AS/VS sense pulse generator, request demux and ready mux
// Optional SENSE_BLANK_EN enables post-pace blanking and drop counting.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sense_pulse_gen
  import sense_pulse_gen_pkg::*;
#(
  parameter int PULSE_CYCLES = 100,
  parameter int GAP_CYCLES   = 50,
  parameter int BLANK_CYCLES = 2000,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  sense_pulse_gen_if.slave  req,
  output logic              AS,
  output logic              VS,
  output logic              busy_a,
  output logic              busy_v,
  output logic [15:0]       sense_cnt_a,
  output logic [15:0]       sense_cnt_v,
  input  logic              AP,
  input  logic              VP,
  output logic [7:0]        drop_cnt
);

  logic req_a, req_v;
  logic ready_a, ready_v;

  assign req_a         = req.req_valid & (req.req_chan == CHAN_A);
  assign req_v         = req.req_valid & (req.req_chan == CHAN_V);
  assign req.req_ready = (req.req_chan == CHAN_V) ? ready_v : ready_a;

`ifdef SENSE_BLANK_EN
  logic       drop_a, drop_v;
  logic [7:0] drop_q;

  // Only one request is presented per cycle, so at most one drop per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if ((drop_a || drop_v) && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  logic unused_pace;
  assign unused_pace = AP | VP;
  assign drop_cnt    = '0;
`endif

  sense_chan_engine #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_eng_a (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_a),
    .ready_o (ready_a),
`ifdef SENSE_BLANK_EN
    .pace_i  (AP),
    .drop_o  (drop_a),
`endif
    .pulse_o (AS),
    .busy_o  (busy_a),
    .cnt_o   (sense_cnt_a)
  );

  sense_chan_engine #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_eng_v (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_v),
    .ready_o (ready_v),
`ifdef SENSE_BLANK_EN
    .pace_i  (VP),
    .drop_o  (drop_v),
`endif
    .pulse_o (VS),
    .busy_o  (busy_v),
    .cnt_o   (sense_cnt_v)
  );

endmodule

`default_nettype wire

// File: doc/sense_pulse_gen.md
Name: sense_pulse_gen

Overview:
Heart-side generator of atrial/ventricular sense events (AS/VS) for the pacemaker under test. Accepts sense requests from the heart model over a valid/ready handshake and drives clean, fixed-width AS/VS pulses into the GPIO mapping layer. Enforces a minimum low gap between pulses on each channel. Counts issued events per channel.

Parameters:
PULSE_CYCLES, 100, AS/VS high time in clk cycles (>=1; 1 us at 100 MHz)
GAP_CYCLES, 50, minimum low time after a pulse before the channel accepts again (>=0)
BLANK_CYCLES, 2000, post-pace blanking window (used only with SENSE_BLANK_EN)
CNT_W, 16, timer width; must hold max(PULSE_CYCLES, GAP_CYCLES, BLANK_CYCLES)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req_valid  input  1  sense request valid
req_chan  input  1  0 = atrial (AS), 1 = ventricular (VS)
req_ready  output  1  the addressed channel can accept this cycle
AS  output  1  atrial sense pulse, registered
VS  output  1  ventricular sense pulse, registered
busy_a  output  1  atrial engine not IDLE
busy_v  output  1  ventricular engine not IDLE
sense_cnt_a  output  16  atrial pulses issued, wraps at 0xFFFF->0
sense_cnt_v  output  16  ventricular pulses issued, wraps
AP  input  1  atrial pace from pacemaker (blanking only)
VP  input  1  ventricular pace from pacemaker (blanking only)
drop_cnt  output  8  requests dropped by blanking, saturating

Behaviour:
- One clock; reset synchronous, active-high. While rst is sampled high: AS, VS, busy_*, sense_cnt_*, drop_cnt = 0; engines IDLE; req_ready = 0.
- Two independent channel engines (A, V). req_ready = ready of the engine selected by req_chan (combinational from state and req_chan). Transfer = req_valid & req_ready.
- Engine FSM: IDLE -> PULSE -> GAP -> IDLE.
  - IDLE: ready = 1. On transfer: load timer, go PULSE; sense_cnt increments on that same edge.
  - PULSE: output high for exactly PULSE_CYCLES cycles, starting the cycle after the transfer (latency 1). Then GAP, or IDLE if GAP_CYCLES = 0.
  - GAP: output low for GAP_CYCLES cycles, ready = 0, then IDLE.
- A transfer at cycle t makes the channel ready again at t+1+PULSE_CYCLES+GAP_CYCLES.
- Requests to a busy channel stall (req_ready = 0). The other channel is unaffected. AS and VS may overlap.
- req_valid held with req_chan changing while not ready: no ordering guarantee is required. The requester must hold req_chan stable until the transfer.
- Reset mid-pulse: output drops on the reset edge. No truncated pulse is extended, and counters clear.
- Outputs are glitch-free registers. No combinational path from req_* to AS/VS.

Optional Feature:
SENSE_BLANK_EN
- Defined:
  - AP and VP pass through a 2-flop synchronizer and rising-edge detect.
  - An edge starts or restarts a BLANK_CYCLES window on its own channel.
  - A request to an IDLE, blanked channel is accepted (ready = 1) but discarded: no pulse, sense_cnt unchanged, drop_cnt +1 (saturates at 255).
  - A pulse already in progress when a pace edge arrives completes normally.
- Undefined: AP/VP ignored, drop_cnt tied 0, no synchronizer logic.

Decomposition:
- Shared package: channel encoding constants (CHAN_A = 0, CHAN_V = 1) and the engine state enum (IDLE, PULSE, GAP), also reused by the heart model.
- Sub-module sense_chan_engine: one FSM, timer, event counter and blank window. Instantiated twice; top holds the request demux and ready mux.

Test Plan:
1. Hold rst 3 cycles with req_valid = 1 -> req_ready, AS, VS, counts all 0. First cycle after release: req_ready = 1.
2. PULSE = 4, GAP = 2; A request accepted at t -> AS high t+1..t+4, low t+5..t+6, req_ready (chan 0) = 1 at t+7, sense_cnt_a = 1.
3. V request held valid continuously -> accepts every 1+PULSE+GAP cycles; VS period 7 cycles, duty 4; 5 pulses give sense_cnt_v = 5.
4. A accepted at t, V accepted at t+1 -> AS high t+1..t+4, VS high t+2..t+5; busy_a and busy_v both set.
5. rst asserted at pulse cycle 2 -> AS = 0 the next cycle, sense_cnt_a = 0, channel ready after release.
6. With SENSE_BLANK_EN, BLANK = 10: AP rises, then an A request 5 cycles later -> no AS pulse, drop_cnt = 1. A request 15 cycles after the edge -> pulse issued.
